// File: rtl/pc_gen.sv
// Fetch PC generator: sequential advance, stall hold, branch/trap redirect,
// and a RUN -> DRAIN -> HALTED wind-down once the program space is exhausted.
module pc_gen #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter logic [XLEN-1:0] PC_LIMIT     = 64'h200,
  parameter int              INST_BYTES   = 4,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 64'h1F0,
  parameter int              DRAIN_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_branch,
  input  logic            trap_req,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            halted,
  output logic            misalign_fault,
  output logic [31:0]     stall_count
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam logic [XLEN-1:0] INC       = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] LAST_PC   = PC_LIMIT - INC;
  localparam logic [XLEN-1:0] ALIGN_MSK = INC - 1'b1;
  localparam logic [7:0]      DRAIN_LD  = 8'(DRAIN_CYCLES - 1);

  logic [1:0] state;
  logic [7:0] drain_cnt;
  logic       br_misaligned;

  assign br_misaligned = |(pc_branch & ALIGN_MSK);
  assign pc_valid      = (state == RUN);
  assign halted        = (state == HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      pc_out         <= RESET_PC;
      drain_cnt      <= '0;
      stall_count    <= '0;
      misalign_fault <= 1'b0;
    end else begin
      misalign_fault <= 1'b0;
      case (state)
        RUN, DRAIN: begin
          // Redirects win even in DRAIN: older in-flight instructions may still branch.
          if (trap_req) begin
            pc_out <= TRAP_VECTOR;
            state  <= RUN;
          end else if (pc_src) begin
            pc_out         <= br_misaligned ? TRAP_VECTOR : pc_branch;
            misalign_fault <= br_misaligned;
            state          <= RUN;
          end else if (state == DRAIN) begin
            if (drain_cnt == '0) state <= HALTED;
            else drain_cnt <= drain_cnt - 1'b1;
          end else if (!pc_write) begin
            if (stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 1'b1;
          end else if (pc_out < LAST_PC) begin
            pc_out <= pc_out + INC;
          end else begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a cycle-level reference model checked every cycle,
// plus literal expectations taken from worked examples.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_write = 1'b0;
  logic        pc_src = 1'b0;
  logic [63:0] pc_branch = '0;
  logic        trap_req = 1'b0;
  logic [63:0] pc_out;
  logic        pc_valid;
  logic        halted;
  logic        misalign_fault;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  pc_gen dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .pc_src(pc_src),
    .pc_branch(pc_branch), .trap_req(trap_req), .pc_out(pc_out),
    .pc_valid(pc_valid), .halted(halted), .misalign_fault(misalign_fault),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = fetching, 1 = draining, 2 = done.
  logic [63:0] m_pc;
  int          m_mode;
  int          m_drain_edges;
  logic [31:0] m_stall;
  logic        m_fault;
  bit          m_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 64'h0; m_mode = 0; m_drain_edges = 0; m_stall = 0; m_fault = 0; m_ok = 1'b1;
    end else if (m_ok) begin
      m_fault = 1'b0;
      if (m_mode == 2) begin
      end else if (trap_req) begin
        m_pc = 64'h1F0; m_mode = 0;
      end else if (pc_src) begin
        if (pc_branch % 4 != 0) begin m_pc = 64'h1F0; m_fault = 1'b1; end
        else m_pc = pc_branch;
        m_mode = 0;
      end else if (m_mode == 1) begin
        m_drain_edges++;
        if (m_drain_edges >= 4) m_mode = 2;
      end else if (!pc_write) begin
        if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      end else if (m_pc + 4 >= 64'h200) begin
        m_mode = 1; m_drain_edges = 0;
      end else begin
        m_pc = m_pc + 4;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      check("model pc_out", pc_out, m_pc);
      check("model pc_valid", 64'(pc_valid), 64'(m_mode == 0));
      check("model halted", 64'(halted), 64'(m_mode == 2));
      check("model misalign_fault", 64'(misalign_fault), 64'(m_fault));
      check("model stall_count", 64'(stall_count), 64'(m_stall));
    end
  end

  task automatic cyc(input logic r, input logic pw, input logic src,
                     input logic trap, input logic [63:0] br);
    rst = r; pc_write = pw; pc_src = src; trap_req = trap; pc_branch = br;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] seq_exp [6];
    logic        seq_pw  [6];
    seq_exp = '{64'h4, 64'h8, 64'hC, 64'hC, 64'hC, 64'h10};
    seq_pw  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    @(negedge clk);
    cyc(1, 0, 0, 0, 0);
    check("reset pc_out", pc_out, 64'h0);
    check("reset pc_valid", 64'(pc_valid), 64'h1);
    check("reset halted", 64'(halted), 64'h0);
    check("reset stall_count", 64'(stall_count), 64'h0);

    // Sequential advance with a two-cycle stall.
    for (int i = 0; i < 6; i++) begin
      cyc(0, seq_pw[i], 0, 0, 0);
      check("seq pc_out", pc_out, seq_exp[i]);
    end
    check("seq stall_count", 64'(stall_count), 64'h2);

    // Branch beats stall.
    cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    check("pre-branch pc", pc_out, 64'h8);
    cyc(0, 0, 1, 0, 64'h40);
    check("branch pc_out", pc_out, 64'h40);
    check("branch no fault", 64'(misalign_fault), 64'h0);

    // Trap beats branch.
    cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 64'h40);
    check("trap pc_out", pc_out, 64'h1F0);

    // Misaligned branch pulses the fault for one cycle.
    cyc(0, 1, 1, 0, 64'h42);
    check("misalign pc_out", pc_out, 64'h1F0);
    check("misalign fault set", 64'(misalign_fault), 64'h1);
    cyc(0, 0, 0, 0, 0);
    check("misalign fault clear", 64'(misalign_fault), 64'h0);

    // Limit, drain and halt.
    cyc(0, 0, 1, 0, 64'h1F8);
    cyc(0, 1, 0, 0, 0);
    check("last pc", pc_out, 64'h1FC);
    cyc(0, 1, 0, 0, 0);
    check("drain pc hold", pc_out, 64'h1FC);
    check("drain pc_valid", 64'(pc_valid), 64'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      check("drain not halted", 64'(halted), 64'h0);
    end
    cyc(0, 1, 0, 0, 0);
    check("halted after drain", 64'(halted), 64'h1);
    cyc(0, 1, 1, 0, 64'h40);
    check("halted ignores branch", pc_out, 64'h1FC);
    cyc(0, 1, 0, 1, 0);
    check("halted ignores trap", pc_out, 64'h1FC);

    // Redirect two cycles into DRAIN returns to RUN.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 64'h1FC);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 64'h100);
    check("drain redirect pc", pc_out, 64'h100);
    check("drain redirect valid", 64'(pc_valid), 64'h1);
    check("drain redirect halted", 64'(halted), 64'h0);

    // Misaligned redirect out of DRAIN.
    cyc(0, 0, 1, 0, 64'h1FC); cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 64'h101);
    check("drain misalign pc", pc_out, 64'h1F0);
    check("drain misalign fault", 64'(misalign_fault), 64'h1);

    // Reset while halted, with stalls accumulated beforehand.
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 64'h1FC); cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
    check("halted before reset", 64'(halted), 64'h1);
    cyc(1, 0, 1, 1, 64'h40);
    check("reset from halt pc", pc_out, 64'h0);
    check("reset from halt halted", 64'(halted), 64'h0);
    check("reset from halt stalls", 64'(stall_count), 64'h0);
    check("reset from halt valid", 64'(pc_valid), 64'h1);
    cyc(0, 1, 0, 0, 0);
    check("post-reset advance", pc_out, 64'h4);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- XLEN, 64, PC width in bits.
- RESET_PC, 0, PC value loaded on reset.
- PC_LIMIT, 64'h200, first byte address beyond program space.
- INST_BYTES, 4, sequential increment; power of two, >=2.
- TRAP_VECTOR, 64'h1F0, redirect target for misaligned branch targets and trap_req.
- DRAIN_CYCLES, 4, cycles to wait after limit before halting; range 1..255.

REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, reset, synchronous, active-high.
- pc_write, in, 1, 1 = advance, 0 = hazard stall.
- pc_src, in, 1, branch/jump redirect request.
- pc_branch, in, XLEN, redirect target.
- trap_req, in, 1, external trap redirect to TRAP_VECTOR.
- pc_out, out, XLEN, current fetch PC (registered).
- pc_valid, out, 1, pc_out is a fetchable address this cycle.
- halted, out, 1, program complete; sticky until rst.
- misalign_fault, out, 1, one-cycle pulse: misaligned pc_branch was rejected.
- stall_count, out, 32, saturating count of stall cycles spent in RUN.

Function
REQ-003 The FSM SHALL have exactly three states: RUN, DRAIN and HALTED.
REQ-004 Per-edge priority SHALL be: rst > trap_req > pc_src > stall (pc_write=0) > sequential increment.
REQ-005 In RUN, when trap_req=1, the block SHALL load pc_out <= TRAP_VECTOR.
REQ-006 In RUN, when pc_src=1 and pc_branch[log2(INST_BYTES)-1:0]==0, the block SHALL load pc_out <= pc_branch.
REQ-007 In RUN, when pc_src=1 and pc_branch is misaligned, the block SHALL load pc_out <= TRAP_VECTOR and assert misalign_fault for the next cycle only.
REQ-008 Redirects (REQ-005..007) SHALL take effect regardless of pc_write.
REQ-009 In RUN, with no redirect and pc_write=0: pc_out SHALL hold and stall_count SHALL increment, saturating at 32'hFFFFFFFF.
REQ-010 In RUN, with no redirect, pc_write=1 and pc_out < PC_LIMIT-INST_BYTES, the block SHALL load pc_out <= pc_out+INST_BYTES, computed modulo 2^XLEN.
REQ-011 In RUN, with no redirect, pc_write=1 and pc_out >= PC_LIMIT-INST_BYTES:
- pc_out SHALL hold;
- the state SHALL go to DRAIN;
- the drain counter SHALL load DRAIN_CYCLES-1.
REQ-012 In DRAIN:
- pc_out SHALL hold and pc_valid SHALL be 0;
- the counter SHALL decrement each cycle regardless of pc_write;
- on an edge where the counter is 0, the state SHALL go to HALTED.
REQ-013 In DRAIN, trap_req or pc_src SHALL apply REQ-005..007 and return the state to RUN, because older in-flight instructions may still redirect.
REQ-014 In HALTED:
- pc_out SHALL hold, pc_valid=0 and halted=1;
- trap_req, pc_src and pc_write SHALL be ignored;
- the only exit SHALL be rst.
REQ-015 pc_valid SHALL be 1 exactly when the state is RUN.
REQ-016 stall_count SHALL not change in DRAIN or HALTED.
REQ-017 The block SHALL never call $finish; completion SHALL be signalled only by halted.

Reset
REQ-018 On a clk edge with rst=1, the block SHALL set pc_out=RESET_PC, state=RUN, pc_valid=1 (visible after the edge), halted=0, misalign_fault=0, stall_count=0 and drain counter=0.
REQ-019 Reset SHALL override pc_write=0, all redirects and every state, including mid-DRAIN and HALTED.
REQ-020 There SHALL be no initial-block reliance; behaviour before the first reset edge is undefined.

Verification
REQ-021 Sequential + stall: rst, then pc_write=1 for 3 cycles, 0 for 2, 1 for 1 -> pc_out 0,4,8,C,C,C,10; stall_count=2.
REQ-022 Branch vs stall: pc_out=8, pc_write=0, pc_src=1, pc_branch=40 -> next pc_out=40, misalign_fault=0; simultaneous trap_req=1 -> pc_out=1F0 instead.
REQ-023 Misaligned branch: pc_src=1, pc_branch=42 -> pc_out=1F0; misalign_fault=1 for one cycle, then 0.
REQ-024 Limit/drain/halt: pc_out=1FC, pc_write=1 -> pc_out stays 1FC, pc_valid=0; after 4 cycles halted=1; further pc_src=1 has no effect.
REQ-025 Redirect in DRAIN: two cycles into DRAIN, pc_src=1, pc_branch=100 -> pc_out=100, pc_valid=1, state RUN, halted never asserted.
REQ-026 Reset while halted: halted=1, assert rst with pc_write=0 -> pc_out=RESET_PC, halted=0, stall_count=0, pc_valid=1.
